// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: default lane geometry, lane/vector types
// and the feeder state encoding.
package conv_pkg;

   localparam int LANE_W = 32;
   localparam int LANES  = 8;

   typedef logic [LANE_W-1:0] lane_t;
   typedef lane_t [LANES-1:0] lane_vec_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } feeder_state_e;

endpackage

// File: rtl/adder_tree_feeder_lane_packer.sv
// lane_packer: fill buffer, lane counter, clear and completion detect for adder_tree_feeder.
// Optional feature: ADDER_TREE_FEEDER_ZERO_PAD_EN lets in_last close a partial vector.
module lane_packer
   import conv_pkg::*;
#(
   parameter  int WIDTH     = LANE_W,
   parameter  int INPUT_NUM = LANES,
   localparam int CNT_W     = $clog2(INPUT_NUM)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_en_i,
   input  logic [WIDTH-1:0]                  wr_data_i,
   input  logic                              wr_last_i,
   input  logic                              clear_i,
   output logic [INPUT_NUM-1:0][WIDTH-1:0]   wr_vec_o,
   output logic                              done_o,
   output logic [CNT_W:0]                    wr_count_o,
   output logic [INPUT_NUM-1:0][WIDTH-1:0]   held_vec_o,
   output logic [CNT_W:0]                    held_count_o,
   output logic                              held_last_o
);

   logic [INPUT_NUM-1:0][WIDTH-1:0] buf_q, buf_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [CNT_W:0]                  held_count_q, held_count_d;
   logic                            held_last_q, held_last_d;
   logic                            at_top;
   logic                            early_close;

   always_comb begin
      at_top = (cnt_q == CNT_W'(INPUT_NUM - 1));
`ifdef ADDER_TREE_FEEDER_ZERO_PAD_EN
      early_close = wr_last_i;
`else
      early_close = 1'b0;
`endif
      done_o     = wr_en_i & (at_top | early_close);
      wr_count_o = {1'b0, cnt_q} + (CNT_W+1)'(1);
      // Buffer as it looks with the current word written; unfilled lanes are already zero.
      wr_vec_o         = buf_q;
      wr_vec_o[cnt_q]  = wr_data_i;
   end

   always_comb begin
      buf_d        = buf_q;
      cnt_d        = cnt_q;
      held_count_d = held_count_q;
      held_last_d  = held_last_q;
      if (clear_i) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (wr_en_i) begin
         buf_d = wr_vec_o;
         if (done_o) begin
            // Vector stays parked here until the output register frees up.
            held_count_d = wr_count_o;
            held_last_d  = wr_last_i;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q        <= '0;
         cnt_q        <= '0;
         held_count_q <= '0;
         held_last_q  <= 1'b0;
      end else begin
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         held_count_q <= held_count_d;
         held_last_q  <= held_last_d;
      end
   end

   assign held_vec_o   = buf_q;
   assign held_count_o = held_count_q;
   assign held_last_o  = held_last_q;

endmodule

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: packs INPUT_NUM serial words into one lane vector for adder_tree.
// Optional feature: ADDER_TREE_FEEDER_ZERO_PAD_EN (in_last closes and zero-pads a partial vector).
module adder_tree_feeder
   import conv_pkg::*;
#(
   parameter  int WIDTH     = LANE_W,
   parameter  int INPUT_NUM = LANES,
   localparam int CNT_W     = $clog2(INPUT_NUM)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  in_data,
   input  logic                              in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [INPUT_NUM-1:0][WIDTH-1:0]   out_data,
   output logic                              out_last,
   output logic [CNT_W:0]                    out_count
);

   if (INPUT_NUM < 2 || (INPUT_NUM & (INPUT_NUM - 1)) != 0) begin : g_bad_input_num
      $error("adder_tree_feeder: INPUT_NUM must be a power of two >= 2");
   end

   feeder_state_e                   state_q;
   logic                            out_valid_q;
   logic [INPUT_NUM-1:0][WIDTH-1:0] out_data_q;
   logic                            out_last_q;
   logic [CNT_W:0]                  out_count_q;

   logic                            accept;
   logic                            out_hs;
   logic                            out_free;
   logic                            done;
   logic                            load_new;
   logic                            load_held;
   logic [INPUT_NUM-1:0][WIDTH-1:0] wr_vec;
   logic [CNT_W:0]                  wr_count;
   logic [INPUT_NUM-1:0][WIDTH-1:0] held_vec;
   logic [CNT_W:0]                  held_count;
   logic                            held_last;

   // Ready is gated by rst directly so the source sees 0 during reset, 1 immediately after.
   assign in_ready  = ~rst & (state_q == FILL);
   assign accept    = in_valid & in_ready;
   assign out_hs    = out_valid_q & out_ready;
   assign out_free  = ~out_valid_q | out_ready;
   assign load_new  = done & out_free;
   assign load_held = (state_q == FULL) & out_hs;

   lane_packer #(
      .WIDTH     (WIDTH),
      .INPUT_NUM (INPUT_NUM)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .wr_en_i      (accept),
      .wr_data_i    (in_data),
      .wr_last_i    (in_last),
      .clear_i      (load_new | load_held),
      .wr_vec_o     (wr_vec),
      .done_o       (done),
      .wr_count_o   (wr_count),
      .held_vec_o   (held_vec),
      .held_count_o (held_count),
      .held_last_o  (held_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_count_q <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (load_new) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= wr_vec;
                  out_last_q  <= in_last;
                  out_count_q <= wr_count;
               end else if (done) begin
                  state_q <= FULL;
               end else if (out_hs) begin
                  out_valid_q <= 1'b0;
               end
            end
            FULL: begin
               // Output register is necessarily occupied here; the swap keeps out_valid high.
               if (load_held) begin
                  state_q     <= FILL;
                  out_data_q  <= held_vec;
                  out_last_q  <= held_last;
                  out_count_q <= held_count;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder (WIDTH=32, INPUT_NUM=8), both macro settings.
module tb_adder_tree_feeder;

   localparam int WIDTH = 32;
   localparam int N     = 8;

   typedef logic [N-1:0][WIDTH-1:0] vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   vec_t             out_data;
   logic             out_last;
   logic [3:0]       out_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   adder_tree_feeder #(
      .WIDTH     (WIDTH),
      .INPUT_NUM (N)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_count (out_count)
   );

   task automatic chk(input string tag, input logic [N*WIDTH-1:0] got, input logic [N*WIDTH-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [WIDTH-1:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   function automatic vec_t seq_vec(input int base, input int n);
      vec_t v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = WIDTH'(base + i);
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   drops;
      int   nvec;
      int   last_k;
      vec_t v;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      step(); step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_out_count", out_count, 0);
      chk("rst_in_ready",  in_ready,  0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Basic vector 1..8
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push(WIDTH'(i), 1'b0);
         if (i < 8) chk("t1_early_valid", out_valid, 0);
      end
      chk("t1_valid", out_valid, 1);
      chk("t1_data",  out_data,  seq_vec(1, 8));
      chk("t1_count", out_count, 8);
      chk("t1_last",  out_last,  0);
      step();
      chk("t1_pulse", out_valid, 0);

      // 24 words back to back
      drops = 0; nvec = 0; last_k = -1;
      for (int k = 0; k < 24; k++) begin
         if (!in_ready) drops++;
         push(WIDTH'(100 + k), 1'b0);
         chk("t2_valid_pattern", out_valid, ((k % 8) == 7) ? 1 : 0);
         if (out_valid) begin
            chk("t2_data", out_data, seq_vec(100 + 8 * nvec, 8));
            if (nvec > 0) chk("t2_gap", k - last_k, 8);
            last_k = k;
            nvec++;
         end
      end
      chk("t2_nvec",  nvec,  3);
      chk("t2_drops", drops, 0);

      // Back-pressure
      do_reset();
      drops = 0;
      for (int i = 0; i < 16; i++) begin
         if (!in_ready) drops++;
         push(WIDTH'(32'h200 + i), 1'b0);
         if (i == 7) chk("t3_v1_valid", out_valid, 1);
      end
      chk("t3_drops",     drops,    0);
      chk("t3_ready_low", in_ready, 0);
      chk("t3_v1_hold",   out_data, seq_vec(32'h200, 8));
      push(WIDTH'(32'h2FF), 1'b0);
      chk("t3_v1_stable", out_data, seq_vec(32'h200, 8));
      chk("t3_stall",     in_ready, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_v2_valid",   out_valid, 1);
      chk("t3_v2_data",    out_data,  seq_vec(32'h208, 8));
      chk("t3_ready_back", in_ready,  1);

      // in_last on lane 2
      do_reset();
      out_ready = 1'b1;
      push(WIDTH'(32'hA), 1'b0);
      push(WIDTH'(32'hB), 1'b0);
      push(WIDTH'(32'hC), 1'b1);
`ifdef ADDER_TREE_FEEDER_ZERO_PAD_EN
      chk("t4_pad_valid", out_valid, 1);
      chk("t4_pad_data",  out_data,  seq_vec(32'hA, 3));
      chk("t4_pad_count", out_count, 3);
      chk("t4_pad_last",  out_last,  1);
      step();
      chk("t4_pad_drain", out_valid, 0);
      v = seq_vec(32'hD, 8);
      for (int i = 0; i < 8; i++) push(v[i], (i == 7) ? 1'b1 : 1'b0);
      chk("t4_full_data", out_data, v);
`else
      chk("t4_nopad_valid", out_valid, 0);
      chk("t4_nopad_cnt",   u_dut.u_packer.cnt_q, 3);
      for (int i = 0; i < 5; i++) push(WIDTH'(32'hD + i), (i == 4) ? 1'b1 : 1'b0);
      chk("t4_full_data", out_data, seq_vec(32'hA, 8));
`endif
      chk("t4_full_valid", out_valid, 1);
      chk("t4_full_count", out_count, 8);
      chk("t4_full_last",  out_last,  1);

      // Reset mid-operation
      do_reset();
      for (int i = 0; i < 8; i++) push(WIDTH'(32'h300 + i), 1'b0);
      for (int i = 0; i < 5; i++) push(WIDTH'(32'h400 + i), 1'b0);
      chk("t5_pending", out_valid, 1);
      rst = 1'b1;
      step();
      chk("t5_rst_valid",    out_valid, 0);
      chk("t5_rst_data",     out_data,  0);
      chk("t5_rst_count",    out_count, 0);
      chk("t5_rst_last",     out_last,  0);
      chk("t5_rst_in_ready", in_ready,  0);
      rst = 1'b0;
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(WIDTH'(32'h500 + i), 1'b0);
      chk("t5_clean_valid", out_valid, 1);
      chk("t5_clean_data",  out_data,  seq_vec(32'h500, 8));
      chk("t5_clean_count", out_count, 8);

      // Handshake coincident with completion
      do_reset();
      for (int i = 0; i < 8; i++) push(WIDTH'(32'h600 + i), 1'b0);
      for (int i = 0; i < 7; i++) push(WIDTH'(32'h700 + i), 1'b0);
      chk("t6_a_valid", out_valid, 1);
      chk("t6_a_data",  out_data,  seq_vec(32'h600, 8));
      out_ready = 1'b1;
      push(WIDTH'(32'h707), 1'b1);
      chk("t6_b_valid", out_valid, 1);
      chk("t6_b_data",  out_data,  seq_vec(32'h700, 8));
      chk("t6_b_count", out_count, 8);
      chk("t6_b_last",  out_last,  1);
      chk("t6_in_ready", in_ready, 1);
      step();
      chk("t6_drain", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adder_tree_feeder.md
# adder_tree_feeder

Serial-to-parallel operand packer that sits in front of `adder_tree` in the convolution datapath. It accepts one `WIDTH`-bit product per cycle over a valid/ready stream and assembles `INPUT_NUM` of them into the lane vector the adder tree consumes. It double-buffers so that one fill buffer and one output register sustain one word per cycle under back-pressure. It also marks the final vector of a reduction window.

## Interface
- `WIDTH`, 32, bit width of each lane/word
- `INPUT_NUM`, 8, lanes per output vector; power of two, ≥2
- `CNT_W`, `$clog2(INPUT_NUM)`, lane index width (derived, not overridden)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  feeder can accept `in_data` this cycle
- `in_data`  in  `WIDTH`  operand word
- `in_last`  in  1  word is the final word of the reduction window
- `out_valid`  out  1  `out_data` holds a complete vector
- `out_ready`  in  1  consumer takes vector this cycle
- `out_data`  out  `[INPUT_NUM-1:0][WIDTH-1:0]`  packed vector, lane 0 = first word accepted
- `out_last`  out  1  vector contains the window's final word
- `out_count`  out  `CNT_W+1`  number of real (non-pad) lanes, 1..`INPUT_NUM`

## Operation
- Input handshake is `in_valid & in_ready`. Output handshake is `out_valid & out_ready`.
- Fill buffer: a lane counter `cnt` starts at 0. Each accepted word is written to lane `cnt`, then `cnt` increments.
- A vector completes when a word is accepted at `cnt == INPUT_NUM-1`, or on `in_last` when padding is enabled (see Configuration).
- On completion:
  - If the output register is empty, or is handshaking this cycle, the vector moves to the output register, `cnt` returns to 0, and the fill buffer lanes are cleared.
  - Otherwise the fill buffer enters state FULL.
- States: FILL (`in_ready=1`) and FULL (`in_ready=0`, vector held complete).
  - FULL → FILL on the cycle the output handshakes. That cycle the held vector moves to the output register.
- `out_valid` stays high with stable `out_data`, `out_last` and `out_count` until the output handshakes.
- A simultaneous output handshake and fill completion loads the new vector. `out_valid` stays 1 with no bubble.
- Lanes at index ≥ `out_count` read as 0.
- There is no arithmetic. Data passes unmodified, with no width change.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_count=0`, `cnt=0`, state FILL.
- `in_ready=0` while `rst` is high, and 1 from the first cycle after.
- Latency: the completing word accepted in cycle t gives `out_valid=1` in cycle t+1 if the output register is free.
- Throughput: one word per cycle sustained while `out_ready=1`. A full vector is emitted every `INPUT_NUM` cycles.
- Back-pressure: at most 2·`INPUT_NUM` words are buffered before `in_ready` falls.
- Reset mid-operation discards the partial fill and the pending output vector.
- `in_valid` with `in_ready=0` has no effect. The word must be held by the source.

## Configuration
- Macro `ADDER_TREE_FEEDER_ZERO_PAD_EN`.
- Defined:
  - `in_last` on any lane completes the vector immediately.
  - Remaining lanes are 0, `out_count` = lanes filled, `out_last=1`.
- Undefined:
  - Vectors complete only at `INPUT_NUM` words, and `out_count` is always `INPUT_NUM`.
  - `out_last` is set only when `in_last` arrives on lane `INPUT_NUM-1`.
  - `in_last` on any other lane is ignored.

## Structure
- Shared package `conv_pkg`: `lane_t` (`logic [WIDTH-1:0]`), `lane_vec_t` (`lane_t [INPUT_NUM-1:0]`), and state enum `feeder_state_e {FILL, FULL}`.
- One sub-module, `lane_packer`: the fill buffer with its lane counter, clear and completion detect.
- The top level holds the output register and the handshake/state logic.

## Test plan
- Reset, then 8 words 1..8 with `out_ready=1` → one cycle after word 8, `out_data`={8,..,1} (lane0=1), `out_count=8`, `out_valid=1` for 1 cycle.
- Continuous 24 words with `out_ready=1` → three vectors, `in_ready` never drops, vectors spaced exactly 8 cycles apart.
- `out_ready=0` while streaming → `in_ready` falls after word 16. The first vector stays stable. Raising `out_ready` for 1 cycle → second vector appears next cycle and `in_ready` returns to 1.
- With `ZERO_PAD_EN`, 3 words 0xA,0xB,0xC with `in_last` on 0xC → `out_data` lanes 0..2 = A,B,C, lanes 3..7 = 0, `out_count=3`, `out_last=1`. Without the macro, same stimulus → no output, `cnt=3`.
- Assert `rst` after 5 words accepted and one vector pending → next cycle `out_valid=0`, all outputs 0. The next 8 words form a clean vector starting at lane 0.
- Output handshake in the same cycle as the 8th word of the next vector → `out_valid` stays 1 and the new vector appears the following cycle with no bubble.
